// File: rtl/seq_pattern_counter_pkg.sv
// Shared limits and reset defaults for the streaming pattern counter.
// Modules derive their fill-counter width from fill_width().
package seq_pattern_counter_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

  localparam logic [PAT_W_MAX-1:0] PAT_RST_DEFAULT = 16'h0005;
  localparam logic                 OVL_RST_DEFAULT = 1'b1;

  // Width needed to hold a fill level of 0..pat_w.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_counter_window.sv
// Serial history window and fill tracking; flags a hit on the bit that
// completes the programmed pattern.
module seq_pattern_counter_window
  import seq_pattern_counter_pkg::*;
#(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             advance,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pat,
  input  logic             ovl,
  output logic             hit
);

  localparam int FILL_W = fill_width(PAT_W);

  // The oldest window bit is shifted out before anyone looks at it,
  // so only the newest PAT_W-1 bits need storage.
  logic [PAT_W-2:0]  hist_reg;
  logic [PAT_W-1:0]  next_win;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;

  assign next_win[0] = bit_in;
  for (genvar gi = 1; gi < PAT_W; gi++) begin : g_shift
    assign next_win[gi] = hist_reg[gi-1];
  end

  assign hit = advance && (fill_reg >= FILL_W'(PAT_W - 1)) && (next_win == pat);

  always_comb begin
    fill_next = fill_reg;
    if (hit) begin
      fill_next = ovl ? FILL_W'(PAT_W) : '0;
    end else if (fill_reg != FILL_W'(PAT_W)) begin
      fill_next = fill_reg + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (advance) begin
      hist_reg <= next_win[PAT_W-2:0];
      fill_reg <= fill_next;
    end
  end

endmodule

// File: rtl/seq_pattern_counter.sv
// Streaming pattern counter: configuration registers, load/clear priority,
// saturating match counter and registered match pulse.
module seq_pattern_counter
  import seq_pattern_counter_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEFAULT),
  parameter logic             OVL_RST = OVL_RST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             count_sat
);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_pattern_counter: PAT_W out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_pattern_counter: CNT_W out of range");
  end

  logic [PAT_W-1:0] pat_reg;
  logic             ovl_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             sat_reg, sat_next;
  logic             match_reg;
  logic             hit;
  logic             advance;

  // A load or clear in the same cycle swallows the presented bit.
  assign advance = bit_valid && !cfg_load && !clear;

  seq_pattern_counter_window #(.PAT_W(PAT_W)) u_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cfg_load || clear),
    .advance (advance),
    .bit_in  (bit_in),
    .pat     (pat_reg),
    .ovl     (ovl_reg),
    .hit     (hit)
  );

  always_comb begin
    count_next = count_reg;
    sat_next   = sat_reg;
    if (hit) begin
      if (count_reg == '1) sat_next = 1'b1;
      else                 count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_reg   <= PAT_RST;
      ovl_reg   <= OVL_RST;
      count_reg <= '0;
      sat_reg   <= 1'b0;
      match_reg <= 1'b0;
    end else if (cfg_load || clear) begin
      if (cfg_load) begin
        pat_reg <= cfg_pattern;
        ovl_reg <= cfg_overlap;
      end
      count_reg <= '0;
      sat_reg   <= 1'b0;
      match_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      sat_reg   <= sat_next;
      match_reg <= hit;
    end
  end

  assign match     = match_reg;
  assign count     = count_reg;
  assign count_sat = sat_reg;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Directed bench for seq_pattern_counter: three instances cover the default
// build, a 4-bit counter (saturation) and a 5-bit pattern.
module tb_seq_pattern_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ld  [3];
  logic        clr [3];
  logic        vld [3];
  logic        bin [3];
  logic        ovl [3];
  logic [15:0] pat [3];

  logic       match_a, match_b, match_c;
  logic [7:0] count_a, count_c;
  logic [3:0] count_b;
  logic       sat_a, sat_b, sat_c;

  int total = 0;
  int bad   = 0;

  seq_pattern_counter dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_load(ld[0]), .cfg_pattern(pat[0][2:0]),
    .cfg_overlap(ovl[0]), .clear(clr[0]), .bit_valid(vld[0]), .bit_in(bin[0]),
    .match(match_a), .count(count_a), .count_sat(sat_a));

  seq_pattern_counter #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_load(ld[1]), .cfg_pattern(pat[1][2:0]),
    .cfg_overlap(ovl[1]), .clear(clr[1]), .bit_valid(vld[1]), .bit_in(bin[1]),
    .match(match_b), .count(count_b), .count_sat(sat_b));

  seq_pattern_counter #(.PAT_W(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .cfg_load(ld[2]), .cfg_pattern(pat[2][4:0]),
    .cfg_overlap(ovl[2]), .clear(clr[2]), .bit_valid(vld[2]), .bit_in(bin[2]),
    .match(match_c), .count(count_c), .count_sat(sat_c));

  function automatic logic get_match(input int d);
    case (d)
      0:       return match_a;
      1:       return match_b;
      default: return match_c;
    endcase
  endfunction

  function automatic logic [63:0] get_count(input int d);
    case (d)
      0:       return 64'(count_a);
      1:       return 64'(count_b);
      default: return 64'(count_c);
    endcase
  endfunction

  function automatic logic get_sat(input int d);
    case (d)
      0:       return sat_a;
      1:       return sat_b;
      default: return sat_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int d, input logic b, output logic m);
    vld[d] = 1'b1;
    bin[d] = b;
    @(posedge clk); #1;
    vld[d] = 1'b0;
    m = get_match(d);
  endtask

  task automatic idle(output logic m);
    @(posedge clk); #1;
    m = 1'b0;
  endtask

  // First bit of the stream is bits[n-1]; mask bit i records match after bit i+1.
  task automatic stream(input int d, input logic [63:0] bits, input int n,
                        output logic [63:0] mask);
    logic mb;
    mask = '0;
    for (int i = 0; i < n; i++) begin
      send(d, bits[n-1-i], mb);
      mask[i] = mb;
    end
    $display("stream dut%0d n=%0d bits=%0h mask=%0h count=%0d sat=%0b",
             d, n, bits, mask, get_count(d), get_sat(d));
  endtask

  // Presents a valid 1 alongside the load; it must be dropped.
  task automatic cfg(input int d, input logic [15:0] p, input logic o);
    ld[d] = 1'b1; pat[d] = p; ovl[d] = o;
    vld[d] = 1'b1; bin[d] = 1'b1;
    @(posedge clk); #1;
    ld[d] = 1'b0; vld[d] = 1'b0;
    $display("cfg dut%0d pattern=%0h overlap=%0b", d, p, o);
  endtask

  task automatic pulse_clear(input int d);
    clr[d] = 1'b1;
    @(posedge clk); #1;
    clr[d] = 1'b0;
    $display("clear dut%0d count=%0d sat=%0b", d, get_count(d), get_sat(d));
  endtask

  initial begin
    logic [63:0] m;
    logic        mb;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld[i] = 0; clr[i] = 0; vld[i] = 0; bin[i] = 0; ovl[i] = 0; pat[i] = '0;
    end
    @(posedge clk); #1;
    chk("rst_count", get_count(0), 64'd0);
    chk("rst_sat", 64'(get_sat(0)), 64'd0);
    chk("rst_match", 64'(get_match(0)), 64'd0);
    chk("rst_count_b", get_count(1), 64'd0);
    rst_n = 1'b1;

    stream(0, 64'b10101, 5, m);
    chk("dflt_mask", m, 64'h14);
    chk("dflt_count", get_count(0), 64'd2);
    chk("dflt_sat", 64'(get_sat(0)), 64'd0);

    cfg(0, 16'h5, 1'b0);
    stream(0, 64'b1010101010, 10, m);
    chk("novl_alt_mask", m, 64'h44);
    chk("novl_alt_count", get_count(0), 64'd2);
    cfg(0, 16'h5, 1'b1);
    stream(0, 64'b1010101010, 10, m);
    chk("ovl_alt_mask", m, 64'h154);
    chk("ovl_alt_count", get_count(0), 64'd4);

    cfg(0, 16'h5, 1'b0);
    stream(0, 64'b10110110, 8, m);
    chk("novl_mix_mask", m, 64'h24);
    chk("novl_mix_count", get_count(0), 64'd2);
    cfg(0, 16'h5, 1'b1);
    stream(0, 64'b10110110, 8, m);
    chk("ovl_mix_mask", m, 64'h24);
    chk("ovl_mix_count", get_count(0), 64'd2);

    // Gaps inside 1,0,1
    cfg(0, 16'h5, 1'b1);
    send(0, 1'b1, mb);
    idle(mb); chk("gap_idle1", 64'(get_match(0)), 64'd0);
    idle(mb);
    send(0, 1'b0, mb);
    idle(mb);
    send(0, 1'b1, mb);
    chk("gap_hit", 64'(mb), 64'd1);
    idle(mb); chk("gap_pulse_end", 64'(get_match(0)), 64'd0);
    chk("gap_count", get_count(0), 64'd1);
    $display("gap test dut0 count=%0d", get_count(0));

    // Clear together with the completing bit
    stream(0, 64'b10, 2, m);
    clr[0] = 1'b1; vld[0] = 1'b1; bin[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0; vld[0] = 1'b0;
    chk("clr_bit_match", 64'(get_match(0)), 64'd0);
    chk("clr_bit_count", get_count(0), 64'd0);
    send(0, 1'b1, mb);
    chk("clr_after_match", 64'(mb), 64'd0);
    $display("clear+bit dut0 count=%0d", get_count(0));

    // Reset mid-stream restores default config and empties the window
    cfg(0, 16'h3, 1'b0);
    stream(0, 64'b10, 2, m);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stream(0, 64'b10101, 5, m);
    chk("rst_mid_mask", m, 64'h14);
    chk("rst_mid_count", get_count(0), 64'd2);

    // Saturation with a 4-bit counter
    stream(1, 64'h5555_5555, 31, m);
    chk("sat15_mask", m, 64'h5555_5554);
    chk("sat15_count", get_count(1), 64'd15);
    chk("sat15_flag", 64'(get_sat(1)), 64'd0);
    stream(1, 64'h155, 10, m);
    chk("sat_more_mask", m, 64'h2AA);
    chk("sat_more_count", get_count(1), 64'd15);
    chk("sat_more_flag", 64'(get_sat(1)), 64'd1);
    pulse_clear(1);
    chk("sat_clr_count", get_count(1), 64'd0);
    chk("sat_clr_flag", 64'(get_sat(1)), 64'd0);

    // 5-bit pattern 11011
    cfg(2, 16'h1B, 1'b1);
    stream(2, 64'b11011011, 8, m);
    chk("p5_ovl_mask", m, 64'h90);
    chk("p5_ovl_count", get_count(2), 64'd2);
    cfg(2, 16'h1B, 1'b0);
    stream(2, 64'b11011011, 8, m);
    chk("p5_novl_mask", m, 64'h10);
    chk("p5_novl_count", get_count(2), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
